seq_magnitude_comparator: RTL

SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

---
 rtl/cmp_pkg.sv | 15 +
 rtl/chunk_comparator.sv | 16 +
 rtl/seq_magnitude_comparator.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM encoding
// and the bit positions of the less/equal/greater flags in a 3-bit flag vector.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int LT = 0;
    localparam int EQ = 1;
    localparam int GT = 2;

endpackage

// File: rtl/chunk_comparator.sv
// Combinational unsigned comparison of one CHUNK-wide slice; lt/eq/gt are one-hot.
module chunk_comparator #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Chunk-serial magnitude comparator, MSB chunk first, with early termination.
// Define SEQ_CMP_SIGNED_EN to add the signed_mode port (two's-complement ordering).
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  x,
    input  logic [WIDTH-1:0]                  y,
    input  logic                              lin,
    input  logic                              ein,
    input  logic                              gin,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic                              signed_mode,
`endif
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              less,
    output logic                              equal,
    output logic                              greater,
    output logic [$clog2(WIDTH/CHUNK):0]      cycles
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(NCHUNK) + 1;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  x_q, y_q;
    logic [2:0]        cas_q;
    logic [2:0]        flags_q, flags_d;
    logic [CW-1:0]     cycles_q, cycles_d;
    logic              load;
    logic [CHUNK-1:0]  x_chunk, y_chunk;
    logic              c_lt, c_eq, c_gt;
`ifdef SEQ_CMP_SIGNED_EN
    logic              sgn_q;
`endif

    // Slice selection; in signed mode the MSB chunk's sign bit is flipped so an
    // unsigned compare yields two's-complement ordering.
    always_comb begin
        x_chunk = x_q[idx_q*CHUNK +: CHUNK];
        y_chunk = y_q[idx_q*CHUNK +: CHUNK];
`ifdef SEQ_CMP_SIGNED_EN
        if (sgn_q && (idx_q == IDXW'(NCHUNK - 1))) begin
            x_chunk[CHUNK-1] = ~x_chunk[CHUNK-1];
            y_chunk[CHUNK-1] = ~y_chunk[CHUNK-1];
        end
`endif
    end

    chunk_comparator #(.W(CHUNK)) u_chunk_cmp (
        .a  (x_chunk),
        .b  (y_chunk),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                 state_d = RUN;
            RUN:     if (!c_eq || idx_q == '0)     state_d = DONE;
            DONE:    if (out_ready)                state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        less      = flags_q[LT];
        equal     = flags_q[EQ];
        greater   = flags_q[GT];
        cycles    = cycles_q;
    end

    // Datapath next-state: chunk index walk, result flags and RUN-cycle count.
    always_comb begin
        idx_d    = idx_q;
        flags_d  = flags_q;
        cycles_d = cycles_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    idx_d = IDXW'(NCHUNK - 1);
                    load  = 1'b1;
                end
            end
            RUN: begin
                if (!c_eq) begin
                    flags_d     = '0;
                    flags_d[LT] = c_lt;
                    flags_d[GT] = c_gt;
                    cycles_d    = CW'(NCHUNK) - CW'(idx_q);
                end else if (idx_q == '0) begin
                    flags_d  = cas_q;
                    cycles_d = CW'(NCHUNK);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= IDXW'(NCHUNK - 1);
            x_q      <= '0;
            y_q      <= '0;
            cas_q    <= '0;
            flags_q  <= '0;
            cycles_q <= '0;
`ifdef SEQ_CMP_SIGNED_EN
            sgn_q    <= 1'b0;
`endif
        end else begin
            idx_q    <= idx_d;
            flags_q  <= flags_d;
            cycles_q <= cycles_d;
            if (load) begin
                x_q   <= x;
                y_q   <= y;
                cas_q <= {gin, ein, lin};
`ifdef SEQ_CMP_SIGNED_EN
                sgn_q <= signed_mode;
`endif
            end
        end
    end

endmodule
